// File: rtl/mem_stage_ctrl.sv
// Purpose: MEM-stage sequencer. Holds one data-cache request per instruction, captures load
//          data, and drives the pipeline stage enables/flushes, load-use stalls and halt.
// Latency: a memory op needs 3 cycles minimum (IDLE -> ACCESS -> DONE/advance) with immediate
//          dhit and ihit high. Backpressure: it waits in ACCESS on dhit and in DONE on ihit.
module mem_stage_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_dREN,
  input  logic              mem_dWEN,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] mem_store,
  input  logic              mem_branch_taken,
  input  logic              mem_halt,
  input  logic              ex_dREN,
  input  logic [4:0]        ex_rt,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [ADDR_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [ADDR_W-1:0] dmemstore,
  output logic [ADDR_W-1:0] load_data,
  output logic              en_ifid,
  output logic              en_idex,
  output logic              en_exmem,
  output logic              en_memwb,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic              halt,
  output logic [CNT_W-1:0]  access_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state;
  state_t next_state;
  logic   req;
  logic   advance;
  logic   loaduse;

  assign req = mem_dREN | mem_dWEN;

  // State register; reset drops straight back to IDLE from any state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: halt wins over a new request; HALTED is only left through reset.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mem_halt) begin
          next_state = HALTED;
        end else if (req) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (dhit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (ihit) begin
          next_state = IDLE;
        end
      end
      HALTED: next_state = HALTED;
      default: next_state = IDLE;
    endcase
  end

  // Request registers: launched from IDLE, held through ACCESS, dropped on dhit.
  // A load takes priority if both enables are seen together.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
    end else if (state == IDLE && !mem_halt && req) begin
      dmemREN   <= mem_dREN;
      dmemWEN   <= mem_dWEN & ~mem_dREN;
      dmemaddr  <= mem_addr;
      dmemstore <= mem_store;
    end else if (state == ACCESS && dhit) begin
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
    end
  end

  // Access-latency counter: cleared at launch, saturating count of every ACCESS cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      access_cycles <= '0;
    end else if (state == IDLE && !mem_halt && req) begin
      access_cycles <= '0;
    end else if (state == ACCESS && access_cycles != {CNT_W{1'b1}}) begin
      access_cycles <= access_cycles + 1'b1;
    end
  end

  // Load data capture on the completing cycle; stores leave the previous value intact.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      load_data <= '0;
    end else if (state == ACCESS && dhit && dmemREN) begin
      load_data <= dmemload;
    end
  end

  // Output logic: pipeline advance, load-use stall and flush decode.
  // A taken branch flushes IF/ID anyway, so it releases the load-use hold on en_ifid.
  always_comb begin
    advance     = 1'b0;
    loaduse     = ex_dREN && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    case (state)
      IDLE:    advance = ihit & ~req & ~mem_halt;
      DONE:    advance = ihit;
      default: advance = 1'b0;
    endcase
    en_exmem    = advance;
    en_memwb    = advance;
    en_idex     = advance;
    en_ifid     = advance & (~loaduse | mem_branch_taken);
    flush_ifid  = advance & mem_branch_taken;
    flush_idex  = advance & (loaduse | mem_branch_taken);
    flush_exmem = advance & mem_branch_taken;
    halt        = (state == HALTED);
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Purpose: directed + randomized bench for mem_stage_ctrl against a transaction-level model.
// Latency: inputs change at negedge, outputs sampled 1-2 time units later, model steps per edge.
// Backpressure: dhit/ihit are withheld directly by the stimulus to exercise both wait points.
module tb_mem_stage_ctrl;
  localparam int AW = 32;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          ihit = 1'b0, dhit = 1'b0;
  logic          mem_dREN = 1'b0, mem_dWEN = 1'b0;
  logic [AW-1:0] mem_addr = '0, mem_store = '0, dmemload = '0;
  logic          mem_branch_taken = 1'b0, mem_halt = 1'b0, ex_dREN = 1'b0;
  logic [4:0]    ex_rt = '0, id_rs = '0, id_rt = '0;
  logic          dmemREN, dmemWEN;
  logic [AW-1:0] dmemaddr, dmemstore, load_data;
  logic          en_ifid, en_idex, en_exmem, en_memwb;
  logic          flush_ifid, flush_idex, flush_exmem, halt;
  logic [CW-1:0] access_cycles;

  mem_stage_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_addr(mem_addr), .mem_store(mem_store),
    .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt),
    .ex_dREN(ex_dREN), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .load_data(load_data),
    .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .halt(halt), .access_cycles(access_cycles)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: one outstanding request, a completed-awaiting-advance flag,
  // a sticky halt, the last captured load value and a plain integer latency count.
  bit          m_halted, m_busy, m_done, m_isload;
  logic [31:0] m_addr, m_store, m_ld;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_busy = 0; m_done = 0; m_isload = 0;
    m_addr = '0; m_store = '0; m_ld = '0; m_cnt = 0;
  endtask

  task automatic compare(input string ph);
    logic       r, adv, lu, br;
    logic [9:0] ctl_obs, ctl_exp;
    logic [7:0] ecnt;
    r   = mem_dREN | mem_dWEN;
    br  = mem_branch_taken;
    adv = ihit && (m_done || (!m_halted && !m_busy && !r && !mem_halt));
    lu  = ex_dREN && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
    ecnt = (m_cnt > 255) ? 8'hFF : 8'(m_cnt);
    ctl_exp = {adv && (!lu || br), adv, adv, adv, adv && br, adv && (lu || br), adv && br,
               m_halted, m_busy && m_isload, m_busy && !m_isload};
    ctl_obs = {en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, flush_exmem,
               halt, dmemREN, dmemWEN};
    chk({ph, ".ctl"}, 32'(ctl_obs), 32'(ctl_exp));
    chk({ph, ".addr"}, dmemaddr, m_busy ? m_addr : 32'h0);
    chk({ph, ".store"}, dmemstore, m_busy ? m_store : 32'h0);
    chk({ph, ".load_data"}, load_data, m_ld);
    chk({ph, ".cycles"}, 32'(access_cycles), 32'(ecnt));
  endtask

  task automatic update();
    if (m_halted) begin
      m_halted = 1;
    end else if (m_busy) begin
      m_cnt++;
      if (dhit) begin
        m_busy = 0;
        m_done = 1;
        if (m_isload) m_ld = dmemload;
      end
    end else if (m_done) begin
      if (ihit) m_done = 0;
    end else if (mem_halt) begin
      m_halted = 1;
    end else if (mem_dREN || mem_dWEN) begin
      m_busy = 1; m_isload = mem_dREN; m_addr = mem_addr; m_store = mem_store; m_cnt = 0;
    end
  endtask

  // Called at a negedge after inputs are set: check, step the model, move to next negedge.
  task automatic cycle(input string ph);
    #1;
    compare(ph);
    update();
    @(negedge CLK);
  endtask

  task automatic do_reset(input string ph);
    #2 nRST = 1'b0;
    #1;
    model_reset();
    compare(ph);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic clear_inputs();
    ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_branch_taken = 0; mem_halt = 0;
    ex_dREN = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
  endtask

  initial begin
    int k;
    model_reset();
    #1;
    compare("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // Load with immediate dhit
    ihit = 1; mem_dREN = 1; mem_addr = 32'h0000_0100; dmemload = 32'hDEAD_BEEF;
    cycle("ld_idle");
    dhit = 1;
    #1 chk("ld_ren_high", 32'(dmemREN), 32'd1);
    chk("ld_addr", dmemaddr, 32'h0000_0100);
    cycle("ld_access");
    dhit = 0;
    #1 chk("ld_memwb_pulse", 32'(en_memwb), 32'd1);
    chk("ld_data", load_data, 32'hDEAD_BEEF);
    chk("ld_cycles", 32'(access_cycles), 32'd1);
    chk("ld_ren_low", 32'(dmemREN), 32'd0);
    cycle("ld_done");
    mem_dREN = 0;
    cycle("ld_back_idle");

    // Store with 4-cycle dhit delay, then DONE with ihit low for 3 cycles
    mem_dWEN = 1; mem_addr = 32'h200; mem_store = 32'h1234_5678; dmemload = 32'h5555_AAAA;
    cycle("st_idle");
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      #1 chk("st_wen_held", 32'(dmemWEN), 32'd1);
      chk("st_store_held", dmemstore, 32'h1234_5678);
      chk("st_en_off", 32'({en_ifid, en_idex, en_exmem, en_memwb}), 32'd0);
      cycle("st_access");
    end
    dhit = 0; ihit = 0;
    #1 chk("st_cycles", 32'(access_cycles), 32'd4);
    chk("st_ld_unchanged", load_data, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      #1 chk("done_wait_memwb", 32'(en_memwb), 32'd0);
      chk("done_wait_noreq", 32'({dmemREN, dmemWEN}), 32'd0);
      cycle("done_wait");
    end
    ihit = 1;
    #1 chk("done_advance", 32'(en_memwb), 32'd1);
    cycle("done_adv");
    mem_dWEN = 0;
    #1 chk("no_reissue", 32'({dmemREN, dmemWEN}), 32'd0);
    cycle("idle_after");

    // Load-use stall, then ex_rt=0 (no stall), then branch overriding load-use
    ex_dREN = 1; ex_rt = 5; id_rs = 5; id_rt = 9;
    #1 chk("lu_en_ifid", 32'(en_ifid), 32'd0);
    chk("lu_flush_idex", 32'(flush_idex), 32'd1);
    chk("lu_en_idex", 32'(en_idex), 32'd1);
    cycle("loaduse");
    ex_rt = 0; id_rs = 0;
    #1 chk("lu0_en_ifid", 32'(en_ifid), 32'd1);
    chk("lu0_flush_idex", 32'(flush_idex), 32'd0);
    cycle("loaduse_r0");
    ex_rt = 5; id_rs = 5; mem_branch_taken = 1;
    #1 chk("br_flushes", 32'({flush_ifid, flush_idex, flush_exmem}), 32'h7);
    chk("br_en_ifid", 32'(en_ifid), 32'd1);
    cycle("branch_lu");
    clear_inputs();

    // Counter saturation on a long store
    ihit = 1; mem_dWEN = 1; mem_addr = 32'h300; mem_store = 32'hCAFE_0001;
    cycle("sat_idle");
    for (int i = 0; i < 300; i++) begin
      dhit = (i == 299);
      cycle("sat_access");
    end
    dhit = 0;
    #1 chk("sat_cycles", 32'(access_cycles), 32'hFF);
    cycle("sat_done");
    mem_dWEN = 0;
    cycle("sat_idle2");

    // Asynchronous reset in the middle of an access
    mem_dREN = 1; mem_addr = 32'h400;
    cycle("rst_idle");
    dhit = 0;
    cycle("rst_access");
    #2 nRST = 1'b0;
    #1 chk("rst_async_ren", 32'(dmemREN), 32'd0);
    model_reset();
    compare("rst_mid");
    @(negedge CLK);
    nRST = 1'b1;
    mem_dREN = 0;
    cycle("rst_idle_after");

    // Halt: sticky, enables stay off even with ihit and requests
    mem_halt = 1;
    cycle("halt_idle");
    mem_halt = 0; mem_dREN = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("halt_sticky", 32'(halt), 32'd1);
      chk("halt_en_off", 32'({en_ifid, en_idex, en_exmem, en_memwb, dmemREN}), 32'd0);
      cycle("halted");
    end
    clear_inputs();
    do_reset("halt_reset");

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      ihit = ($urandom_range(0, 3) != 0);
      dhit = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, 3);
      mem_dREN = (k == 1 || k == 3);
      mem_dWEN = (k == 2 || k == 3);
      mem_addr = $urandom; mem_store = $urandom; dmemload = $urandom;
      mem_branch_taken = ($urandom_range(0, 3) == 0);
      mem_halt = ($urandom_range(0, 149) == 0);
      ex_dREN = 1'($urandom_range(0, 1));
      ex_rt = 5'($urandom_range(0, 3));
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      cycle("rnd");
      if ((m_halted && $urandom_range(0, 9) == 0) || (m_busy && $urandom_range(0, 99) == 0))
        do_reset("rnd_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
